// File: rtl/vdp_cpu_if.sv
// CPU-side front end of the VDP: TMS9918-style data/control ports, register
// file R0-R7, auto-incrementing VRAM address, read-ahead buffer, status flag
// and interrupt gating.
module vdp_cpu_if #(
   parameter int unsigned ADDR_W = 14
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              cpu_port,
   input  logic              cpu_wr,
   input  logic              cpu_rd,
   input  logic [7:0]        cpu_din,
   output logic [7:0]        cpu_dout,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [7:0]        vram_wdata,
   input  logic [7:0]        vram_rdata,
   output logic              vram_wr,
   output logic              vram_rd,
   input  logic              frame_n_int,
   output logic              n_int,
   output logic [1:0]        mode,
   output logic [13:0]       name_table_addr,
   output logic [13:0]       font_addr,
   output logic [13:0]       color_table_addr,
   output logic [13:0]       sprite_attr_addr,
   output logic [13:0]       sprite_pattern_table_addr,
   output logic [3:0]        text_color,
   output logic [3:0]        back_color,
   output logic              video_on
);

   typedef enum logic [1:0] {
      PF_IDLE,
      PF_FETCH,
      PF_LATCH
   } pf_state_t;

   pf_state_t         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              latch_flag_q, latch_flag_d;
   logic [7:0]        latch_byte_q, latch_byte_d;
   logic [7:0]        rbuf_q, rbuf_d;
   logic              f_q, f_d;
   logic              frame_q;
   logic              vram_wr_q, vram_wr_d;
   logic [7:0]        vram_wdata_q, vram_wdata_d;
   logic [7:0]        regs_q [8];
   logic [7:0]        regs_d [8];

   logic              wr_acc;
   logic              rd_acc;
   logic              frame_fall;
   logic [ADDR_W-1:0] addr_inc;

   // A write strobe wins over a simultaneous read strobe.
   assign wr_acc     = cpu_wr;
   assign rd_acc     = cpu_rd & ~cpu_wr;
   assign frame_fall = frame_q & ~frame_n_int;
   assign addr_inc   = addr_q + ADDR_W'(1);

   // State register for the prefetch FSM, address, latch, buffer and registers.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q      <= PF_IDLE;
         addr_q       <= '0;
         latch_flag_q <= 1'b0;
         latch_byte_q <= '0;
         rbuf_q       <= '0;
         f_q          <= 1'b0;
         frame_q      <= 1'b1;
         vram_wr_q    <= 1'b0;
         vram_wdata_q <= '0;
         for (int unsigned i = 0; i < 8; i++) regs_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         latch_flag_q <= latch_flag_d;
         latch_byte_q <= latch_byte_d;
         rbuf_q       <= rbuf_d;
         f_q          <= f_d;
         frame_q      <= frame_n_int;
         vram_wr_q    <= vram_wr_d;
         vram_wdata_q <= vram_wdata_d;
         for (int unsigned i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
      end
   end

   // Next-state logic: prefetch sequencing first, CPU accesses override it.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      latch_flag_d = latch_flag_q;
      latch_byte_d = latch_byte_q;
      rbuf_d       = rbuf_q;
      vram_wr_d    = 1'b0;
      vram_wdata_d = vram_wdata_q;
      for (int unsigned i = 0; i < 8; i++) regs_d[i] = regs_q[i];

      // Status flag: a coincident frame edge beats the clearing read.
      f_d = f_q;
      if (rd_acc && cpu_port) f_d = 1'b0;
      if (frame_fall)         f_d = 1'b1;

      // vram_rd is issued in FETCH; the read data is valid during LATCH and
      // is captured on the way back to IDLE.
      unique case (state_q)
         PF_FETCH: state_d = PF_LATCH;
         PF_LATCH: begin
            rbuf_d  = vram_rdata;
            addr_d  = addr_inc;
            state_d = PF_IDLE;
         end
         default:  state_d = PF_IDLE;
      endcase

      // Post-increment once the write pulse has been presented.
      if (vram_wr_q) addr_d = addr_inc;

      if (wr_acc && !cpu_port) begin
         // Data write; any in-flight prefetch is dropped without side effects.
         vram_wr_d    = 1'b1;
         vram_wdata_d = cpu_din;
         rbuf_d       = cpu_din;
         latch_flag_d = 1'b0;
         if (state_q != PF_IDLE) begin
            state_d = PF_IDLE;
            addr_d  = addr_q;
         end
      end else if (wr_acc && cpu_port) begin
         if (!latch_flag_q) begin
            latch_byte_d = cpu_din;
            latch_flag_d = 1'b1;
         end else begin
            latch_flag_d = 1'b0;
            if (cpu_din[7]) begin
               regs_d[cpu_din[2:0]] = latch_byte_q;
            end else begin
               addr_d = ADDR_W'({cpu_din[5:0], latch_byte_q});
               if (!cpu_din[6]) state_d = PF_FETCH;
            end
         end
      end else if (rd_acc && !cpu_port) begin
         // Data read restarts the prefetch at the current, unincremented address.
         latch_flag_d = 1'b0;
         rbuf_d       = rbuf_q;
         addr_d       = addr_q;
         state_d      = PF_FETCH;
      end else if (rd_acc && cpu_port) begin
         latch_flag_d = 1'b0;
      end
   end

   // Display mode from the M1/M3/M2 bits, in priority order.
   always_comb begin
      if (regs_q[1][4])      mode = 2'd0;
      else if (regs_q[0][1]) mode = 2'd2;
      else if (regs_q[1][3]) mode = 2'd3;
      else                   mode = 2'd1;
   end

   assign cpu_dout   = cpu_port ? {f_q, 7'b0} : rbuf_q;
   assign vram_addr  = addr_q;
   assign vram_wdata = vram_wdata_q;
   assign vram_wr    = vram_wr_q;
   assign vram_rd    = (state_q == PF_FETCH);
   assign n_int      = ~(f_q & regs_q[1][5]);
   assign video_on   = regs_q[1][6];

   assign name_table_addr           = {regs_q[2][3:0], 10'b0};
   assign color_table_addr          = {regs_q[3], 6'b0};
   assign font_addr                 = {regs_q[4][2:0], 11'b0};
   assign sprite_attr_addr          = {regs_q[5][6:0], 7'b0};
   assign sprite_pattern_table_addr = {regs_q[6][2:0], 11'b0};
   assign text_color                = regs_q[7][7:4];
   assign back_color                = regs_q[7][3:0];

   logic unused_reg_bits;
   assign unused_reg_bits = ^{regs_q[0][7:2], regs_q[0][0], regs_q[1][7],
                              regs_q[1][2:0], regs_q[2][7:4], regs_q[4][7:3],
                              regs_q[5][7], regs_q[6][7:3]};

endmodule

// File: tb/tb_vdp_cpu_if.sv
// Randomised scoreboard bench for vdp_cpu_if with a transaction-level model.
module tb_vdp_cpu_if;

   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic        cpu_port = 1'b0;
   logic        cpu_wr = 1'b0;
   logic        cpu_rd = 1'b0;
   logic [7:0]  cpu_din = '0;
   logic [7:0]  cpu_dout;
   logic [13:0] vram_addr;
   logic [7:0]  vram_wdata;
   logic [7:0]  vram_rdata;
   logic        vram_wr;
   logic        vram_rd;
   logic        frame_n_int = 1'b1;
   logic        n_int;
   logic [1:0]  mode;
   logic [13:0] name_table_addr, font_addr, color_table_addr;
   logic [13:0] sprite_attr_addr, sprite_pattern_table_addr;
   logic [3:0]  text_color, back_color;
   logic        video_on;

   vdp_cpu_if #(.ADDR_W(14)) dut (
      .clk(clk), .n_reset(n_reset), .cpu_port(cpu_port), .cpu_wr(cpu_wr),
      .cpu_rd(cpu_rd), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
      .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
      .vram_wr(vram_wr), .vram_rd(vram_rd), .frame_n_int(frame_n_int),
      .n_int(n_int), .mode(mode), .name_table_addr(name_table_addr),
      .font_addr(font_addr), .color_table_addr(color_table_addr),
      .sprite_attr_addr(sprite_attr_addr),
      .sprite_pattern_table_addr(sprite_pattern_table_addr),
      .text_color(text_color), .back_color(back_color), .video_on(video_on)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_wr;
      logic [13:0] addr;
      logic [7:0]  data;
   } vtx_t;

   vtx_t       vq[$];
   logic [7:0] rdq[$];
   int         errors = 0;
   int         checks = 0;

   // Reference model state.
   logic [7:0]  ref_mem [16384];
   logic [7:0]  m_regs [8];
   logic [13:0] m_addr;
   bit          m_latch;
   logic [7:0]  m_lbyte;
   logic [7:0]  m_rbuf;
   bit          m_f;

   function automatic logic [7:0] pat(input logic [13:0] a);
      return a[7:0] ^ {a[13:8], 2'b10};
   endfunction

   // Video-side VRAM: one-cycle read latency, preload port for the bench.
   logic [7:0]  vmem [16384];
   bit          mem_ready = 1'b0;
   logic        pre_we = 1'b0;
   logic [13:0] pre_addr = '0;
   logic [7:0]  pre_data = '0;

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 16384; i++) vmem[i] <= pat(14'(i));
         mem_ready <= 1'b1;
      end else begin
         if (pre_we)  vmem[pre_addr] <= pre_data;
         if (vram_wr) vmem[vram_addr] <= vram_wdata;
         if (vram_rd) vram_rdata <= vmem[vram_addr];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a VRAM strobe or a CPU read.
   vtx_t       mon_t;
   logic [7:0] mon_r;
   always @(negedge clk) begin
      if (vram_wr || vram_rd) begin
         if (vq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL vram_unexpected: actual wr=%0d rd=%0d addr=0x%0h required=no access",
                     vram_wr, vram_rd, vram_addr);
         end else begin
            mon_t = vq.pop_front();
            chk("vram_kind", {30'b0, vram_wr, vram_rd}, mon_t.is_wr ? 32'd2 : 32'd1);
            chk("vram_addr", 32'(vram_addr), 32'(mon_t.addr));
            if (mon_t.is_wr) chk("vram_wdata", 32'(vram_wdata), 32'(mon_t.data));
         end
      end
      if (cpu_rd && !cpu_wr) begin
         if (rdq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cpu_read_unexpected: actual=0x%0h required=no read", cpu_dout);
         end else begin
            mon_r = rdq.pop_front();
            chk(cpu_port ? "status_read" : "data_read", 32'(cpu_dout), 32'(mon_r));
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_addr  = '0;
      m_latch = 1'b0;
      m_lbyte = '0;
      m_rbuf  = '0;
      m_f     = 1'b0;
   endtask

   task automatic model_prefetch();
      vtx_t t;
      t.is_wr = 1'b0;
      t.addr  = m_addr;
      t.data  = '0;
      vq.push_back(t);
      m_rbuf = ref_mem[m_addr];
      m_addr = m_addr + 14'd1;
   endtask

   // One CPU access: update the model, queue expectations, drive the strobe,
   // then leave a gap of at least three clocks between strobes.
   task automatic cpu_op(input bit port, input bit wr, input bit rd, input logic [7:0] d);
      vtx_t t;
      if (wr) begin
         if (!port) begin
            t.is_wr = 1'b1;
            t.addr  = m_addr;
            t.data  = d;
            vq.push_back(t);
            ref_mem[m_addr] = d;
            m_rbuf  = d;
            m_addr  = m_addr + 14'd1;
            m_latch = 1'b0;
         end else if (!m_latch) begin
            m_lbyte = d;
            m_latch = 1'b1;
         end else begin
            m_latch = 1'b0;
            if (d[7]) m_regs[d[2:0]] = m_lbyte;
            else begin
               m_addr = {d[5:0], m_lbyte};
               if (!d[6]) model_prefetch();
            end
         end
      end else if (rd) begin
         if (!port) begin
            rdq.push_back(m_rbuf);
            model_prefetch();
         end else begin
            rdq.push_back({m_f, 7'b0});
            m_f = 1'b0;
         end
         m_latch = 1'b0;
      end
      cpu_port = port;
      cpu_wr   = wr;
      cpu_rd   = rd;
      cpu_din  = d;
      @(posedge clk); #1;
      cpu_wr = 1'b0;
      cpu_rd = 1'b0;
      repeat (2 + $urandom_range(0, 2)) @(posedge clk);
      #1;
   endtask

   task automatic frame_pulse();
      frame_n_int = 1'b0;
      @(posedge clk); #1;
      frame_n_int = 1'b1;
      m_f = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic preload(input logic [13:0] a, input logic [7:0] d);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = d;
      @(posedge clk); #1;
      pre_we = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic check_cfg();
      logic [1:0] em;
      if (m_regs[1][4])      em = 2'd0;
      else if (m_regs[0][1]) em = 2'd2;
      else if (m_regs[1][3]) em = 2'd3;
      else                   em = 2'd1;
      chk("mode", 32'(mode), 32'(em));
      chk("video_on", 32'(video_on), 32'(m_regs[1][6]));
      chk("n_int", 32'(n_int), (m_f && m_regs[1][5]) ? 32'd0 : 32'd1);
      chk("name_table_addr", 32'(name_table_addr), 32'(m_regs[2] % 16) * 1024);
      chk("color_table_addr", 32'(color_table_addr), 32'(m_regs[3]) * 64);
      chk("font_addr", 32'(font_addr), 32'(m_regs[4] % 8) * 2048);
      chk("sprite_attr_addr", 32'(sprite_attr_addr), 32'(m_regs[5] % 128) * 128);
      chk("sprite_pattern_addr", 32'(sprite_pattern_table_addr), 32'(m_regs[6] % 8) * 2048);
      chk("text_color", 32'(text_color), 32'(m_regs[7] / 16));
      chk("back_color", 32'(back_color), 32'(m_regs[7] % 16));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: actual=no finish required=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int op;
      for (int i = 0; i < 16384; i++) ref_mem[i] = pat(14'(i));
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_reset = 1'b1;
      chk("rst_mode", 32'(mode), 32'd1);
      chk("rst_video_on", 32'(video_on), 32'd0);
      chk("rst_n_int", 32'(n_int), 32'd1);
      chk("rst_name_table", 32'(name_table_addr), 32'd0);
      chk("rst_vram_wr", 32'(vram_wr), 32'd0);
      chk("rst_vram_rd", 32'(vram_rd), 32'd0);
      chk("rst_dout", 32'(cpu_dout), 32'd0);
      check_cfg();

      // Register writes and decode.
      cpu_op(1, 1, 0, 8'h00); cpu_op(1, 1, 0, 8'h82);
      check_cfg();
      chk("name_r2_00", 32'(name_table_addr), 32'h0000);
      cpu_op(1, 1, 0, 8'h0F); cpu_op(1, 1, 0, 8'h82);
      check_cfg();
      chk("name_r2_0f", 32'(name_table_addr), 32'h3C00);
      cpu_op(1, 1, 0, 8'h10); cpu_op(1, 1, 0, 8'h81);
      check_cfg();
      chk("mode_text", 32'(mode), 32'd0);

      // Write setup, data writes, wrap at the top of VRAM.
      cpu_op(1, 1, 0, 8'h00); cpu_op(1, 1, 0, 8'h58);
      cpu_op(0, 1, 0, 8'hAA); cpu_op(0, 1, 0, 8'h55);
      cpu_op(1, 1, 0, 8'hFF); cpu_op(1, 1, 0, 8'h7F);
      cpu_op(0, 1, 0, 8'h11); cpu_op(0, 1, 0, 8'h22);

      // Read setup with read-ahead.
      preload(14'h2000, 8'h12);
      preload(14'h2001, 8'h34);
      cpu_op(1, 1, 0, 8'h00); cpu_op(1, 1, 0, 8'h20);
      cpu_op(0, 0, 1, 8'h00); cpu_op(0, 0, 1, 8'h00);

      // Frame interrupt and status clearing.
      cpu_op(1, 1, 0, 8'h20); cpu_op(1, 1, 0, 8'h81);
      frame_pulse();
      chk("n_int_asserted", 32'(n_int), 32'd0);
      cpu_op(1, 0, 1, 8'h00);
      check_cfg();
      cpu_op(1, 0, 1, 8'h00);

      // Status read resets a half-written control pair.
      cpu_op(1, 1, 0, 8'h34);
      cpu_op(1, 0, 1, 8'h00);
      cpu_op(1, 1, 0, 8'h00); cpu_op(1, 1, 0, 8'h40);
      cpu_op(0, 1, 0, 8'h5A);

      // Frame edge coinciding with a clearing status read: flag stays set.
      rdq.push_back({m_f, 7'b0});
      cpu_port = 1'b1; cpu_rd = 1'b1; frame_n_int = 1'b0;
      @(posedge clk); #1;
      cpu_rd = 1'b0; frame_n_int = 1'b1;
      m_f = 1'b1; m_latch = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_cfg();
      cpu_op(1, 0, 1, 8'h00);

      // Simultaneous write and read strobes: only the write happens.
      cpu_op(0, 1, 1, 8'h77);

      // Read-ahead across the address wrap.
      cpu_op(1, 1, 0, 8'hFF); cpu_op(1, 1, 0, 8'h3F);
      cpu_op(0, 0, 1, 8'h00); cpu_op(0, 0, 1, 8'h00);

      // Randomised traffic.
      for (int n = 0; n < 300; n++) begin
         op = $urandom_range(0, 7);
         case (op)
            0: begin
               cpu_op(1, 1, 0, 8'($urandom));
               cpu_op(1, 1, 0, 8'h80 | 8'($urandom_range(0, 7)));
               check_cfg();
            end
            1: begin
               cpu_op(1, 1, 0, 8'($urandom));
               cpu_op(1, 1, 0, {1'b0, 1'($urandom), 6'($urandom)});
            end
            2: cpu_op(0, 1, 0, 8'($urandom));
            3: cpu_op(0, 0, 1, 8'h00);
            4: cpu_op(1, 0, 1, 8'h00);
            5: begin frame_pulse(); check_cfg(); end
            6: cpu_op(1, 1, 0, 8'($urandom));
            default: cpu_op(1'($urandom), 1, 1, 8'($urandom));
         endcase
      end

      // Reset while a prefetch is in FETCH: no strobes may follow.
      cpu_op(1, 1, 0, 8'h00); cpu_op(1, 1, 0, 8'h80);
      cpu_op(1, 1, 0, 8'h55);
      cpu_port = 1'b1; cpu_wr = 1'b1; cpu_din = 8'h25;
      @(posedge clk); #1;
      cpu_wr  = 1'b0;
      n_reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_reset = 1'b1;
      model_reset();
      chk("mid_rst_vram_rd", 32'(vram_rd), 32'd0);
      chk("mid_rst_vram_wr", 32'(vram_wr), 32'd0);
      chk("mid_rst_dout", 32'(cpu_dout), 32'd0);
      check_cfg();
      repeat (4) @(posedge clk);
      #1;
      cpu_op(0, 1, 0, 8'hC3);

      repeat (5) @(posedge clk);
      #1;
      chk("vram_queue_drained", 32'(vq.size()), 32'd0);
      chk("read_queue_drained", 32'(rdq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vdp_cpu_if.md
Name: vdp_cpu_if

Overview:
- CPU-side front end of the VDP; sits between the Z80 I/O decode and the video block.
- Implements the TMS9918 two-port protocol: data port and control port, two-byte address/register latch, auto-incrementing VRAM address, read-ahead buffer, status register and registers R0–R7.
- Drives the video block's VRAM port A (address/data/strobes) and its configuration inputs: mode, table bases, colours and video_on.
- Gates the video block's frame interrupt into the CPU interrupt line.

Parameters:
ADDR_W, 14, VRAM address width.

Ports:
clk  input  1  CPU clock; same clock as video cpu_clk.
n_reset  input  1  asynchronous active-low reset.
cpu_port  input  1  0 = data port (0x98), 1 = control port (0x99).
cpu_wr  input  1  one-cycle write strobe, already chip-selected.
cpu_rd  input  1  one-cycle read strobe, already chip-selected.
cpu_din  input  8  CPU write data.
cpu_dout  output  8  CPU read data. Combinational: data port gives the read buffer; control port gives the status byte.
vram_addr  output  14  to video vga_addr.
vram_wdata  output  8  to video vga_din.
vram_rdata  input  8  from video vga_dout; valid the cycle after vram_rd.
vram_wr  output  1  one-cycle write pulse.
vram_rd  output  1  one-cycle read pulse.
frame_n_int  input  1  video n_int, active low.
n_int  output  1  CPU interrupt, active low.
mode  output  2  to video mode.
name_table_addr, font_addr, color_table_addr, sprite_attr_addr, sprite_pattern_table_addr  output  14 each  table bases.
text_color, back_color  output  4 each  from R7.
video_on  output  1  R1 bit 6.

Behaviour:
Reset (asynchronous):
- R0–R7 = 0; VRAM address = 0; latch flag = 0; latched byte = 0; read buffer = 0; F = 0.
- Pending fetch cleared; vram_wr = vram_rd = 0; n_int = 1; video_on = 0; mode = 1; all table bases = 0.

Register decode:
- name_table_addr = R2[3:0]<<10.
- color_table_addr = R3<<6.
- font_addr = R4[2:0]<<11.
- sprite_attr_addr = R5[6:0]<<7.
- sprite_pattern_table_addr = R6[2:0]<<11.
- text_color = R7[7:4]; back_color = R7[3:0].
- mode priority: R1[4] (M1) → 0 (text); else R0[1] (M3) → 2; else R1[3] (M2) → 3; else 1 (Graphics I).

Control-port write:
- Latch flag 0: store cpu_din as the latched byte; set flag.
- Latch flag 1: clear flag, then act on cpu_din:
  - bit7 = 1: R[cpu_din[2:0]] <= latched byte. Takes effect on outputs the next cycle.
  - bit7 = 0: address = {cpu_din[5:0], latched byte}.
  - bit7 = 0 and bit6 = 0 (read setup): also start a prefetch.

Data-port write:
- Next cycle: vram_wr = 1, vram_addr = current address, vram_wdata = cpu_din.
- Read buffer <= cpu_din.
- Address increments after the pulse.
- Clears the latch flag.

Data-port read:
- cpu_dout = read buffer during the strobe.
- Then start a prefetch; clears the latch flag.

Prefetch FSM:
- IDLE → FETCH: vram_rd = 1 for one cycle at the current address.
- FETCH → LATCH: read buffer <= vram_rdata; address += 1.
- LATCH → IDLE.

Status:
- Byte = {F, 7'b0}.
- F sets on a falling edge of frame_n_int, using a one-flop edge detector.
- Status read: cpu_dout shows the current F; F is cleared the cycle after the strobe; latch flag is cleared.
- If an edge and a clearing read coincide, F ends at 1 (set wins).

Interrupt: n_int = !(F & R1[5]), combinational.

Address arithmetic: 14-bit modulo; 0x3FFF + 1 = 0x0000.

Strobe spacing and collisions:
- CPU strobes are at least 3 clk apart.
- If a data-port access arrives while the FSM is in FETCH or LATCH, the pending prefetch is abandoned: no buffer update, no increment. The new access proceeds.
- cpu_wr and cpu_rd high in the same cycle: the write is executed and the read is ignored.

Reset mid-operation: the FSM returns to IDLE at once; no further vram strobes are issued.

Test Plan:
- Reset release → mode = 1, video_on = 0, n_int = 1, name_table_addr = 0, vram_wr = vram_rd = 0.
- Control writes 0x00, 0x82 → R2 = 0 → name_table_addr = 0x0000. Writes 0x0F, 0x82 → 0x3C00. Writes 0x10, 0x81 → mode = 0, video_on = 0.
- Control 0x00, 0x58 (write setup to 0x1800); data writes 0xAA, 0x55 → vram_wr pulses at 0x1800 with 0xAA and at 0x1801 with 0x55; then a control 0xFF, 0x7F and data write 0x11 hits 0x3FFF, and the next write goes to 0x0000.
- VRAM preloaded 0x2000 = 0x12, 0x2001 = 0x34; control 0x00, 0x20 → one vram_rd at 0x2000; first data read returns 0x12, the second returns 0x34.
- R1 = 0x20; drive frame_n_int low → n_int = 0 within 2 cycles; status read returns 0x80, then n_int = 1 and the next status read returns 0x00.
- Single control write 0x34, then a status read, then control 0x00, 0x40 → address = 0x0000, not 0x0034 (latch flag was reset).
